cache_control_nway_wb: RTL and testbench

- Parametrised N-way set-associative cache controller: write-back, write-allocate; successor to the 2-way read-only controller.
- Sits between the CPU memory port and physical memory and drives a per-way datapath (data, tag, valid and dirty arrays).
- Tracks hit/miss and victim selection, writes back dirty victims, then fills from pmem.
- Replacement state (LRU/PLRU) lives outside; this block consumes its victim index and emits update strobes.

---
 rtl/cache_control_nway_wb_if.sv | 39 +++
 rtl/cache_control_nway_wb.sv | 178 +++++++++++++++++
 tb/tb_cache_control_nway_wb.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/cache_control_nway_wb_if.sv
// CPU/pmem handshake and per-way datapath control bundle for cache_control_nway_wb.
// master: request side and datapath status; slave: the controller.
interface cache_control_nway_wb_if #(
   parameter int WAYS = 4
);
   localparam int WAY_W = $clog2(WAYS);

   logic             mem_read;
   logic             mem_write;
   logic             mem_resp;
   logic             pmem_resp;
   logic             pmem_read;
   logic             pmem_write;
   logic [WAYS-1:0]  way_hit;
   logic [WAYS-1:0]  way_valid;
   logic [WAYS-1:0]  way_dirty;
   logic [WAY_W-1:0] lru_way;
   logic [WAYS-1:0]  load_data;
   logic [WAYS-1:0]  load_tag;
   logic [WAYS-1:0]  set_dirty;
   logic [WAYS-1:0]  clr_dirty;
   logic             data_sel;
   logic             pmem_addr_sel;
   logic [WAY_W-1:0] victim_way;
   logic             lru_update;
   logic [WAY_W-1:0] lru_touch_way;

   modport slave (
      input  mem_read, mem_write, pmem_resp, way_hit, way_valid, way_dirty, lru_way,
      output mem_resp, pmem_read, pmem_write, load_data, load_tag, set_dirty, clr_dirty,
             data_sel, pmem_addr_sel, victim_way, lru_update, lru_touch_way
   );

   modport master (
      output mem_read, mem_write, pmem_resp, way_hit, way_valid, way_dirty, lru_way,
      input  mem_resp, pmem_read, pmem_write, load_data, load_tag, set_dirty, clr_dirty,
             data_sel, pmem_addr_sel, victim_way, lru_update, lru_touch_way
   );
endinterface

// File: rtl/cache_control_nway_wb.sv
// N-way write-back/write-allocate cache controller: zero-wait hits, misses take writeback+fill+1 cycles.
// CPU holds its request until mem_resp; optional saturating perf counters under CACHE_PERF_CNT_EN.
module cache_control_nway_wb #(
   parameter int WAYS = 4
`ifdef CACHE_PERF_CNT_EN
   , parameter int CNT_W = 32
`endif
) (
   input  logic                   clk,
   input  logic                   rst,
   cache_control_nway_wb_if.slave bus
`ifdef CACHE_PERF_CNT_EN
   , output logic [CNT_W-1:0]     hit_count
   , output logic [CNT_W-1:0]     miss_count
   , output logic [CNT_W-1:0]     wb_count
`endif
);
   localparam int WAY_W = $clog2(WAYS);

   typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_e;

   state_e           state_q, state_d;
   logic [WAY_W-1:0] victim_way_q, victim_way_d;

   logic             req, any_hit, any_inv;
   logic [WAY_W-1:0] hit_idx, inv_idx, victim;
   logic             mem_resp, pmem_read, pmem_write, data_sel, pmem_addr_sel, lru_update;
   logic [WAYS-1:0]  load_data, load_tag, set_dirty, clr_dirty;
   logic [WAY_W-1:0] lru_touch_way;
   logic             hit_evt, miss_evt, wb_evt;

   always_comb begin
      hit_idx = '0;
      inv_idx = '0;
      // Scan downward so the lowest matching index wins.
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (bus.way_hit[i])    hit_idx = WAY_W'(i);
         if (!bus.way_valid[i]) inv_idx = WAY_W'(i);
      end
   end

   assign req     = bus.mem_read | bus.mem_write;
   assign any_hit = |bus.way_hit;
   assign any_inv = ~&bus.way_valid;
   assign victim  = any_inv ? inv_idx : bus.lru_way;

   always_comb begin
      state_d       = state_q;
      victim_way_d  = victim_way_q;
      mem_resp      = 1'b0;
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
      load_data     = '0;
      load_tag      = '0;
      set_dirty     = '0;
      clr_dirty     = '0;
      data_sel      = 1'b0;
      pmem_addr_sel = 1'b0;
      lru_update    = 1'b0;
      lru_touch_way = '0;
      hit_evt       = 1'b0;
      miss_evt      = 1'b0;
      wb_evt        = 1'b0;
      case (state_q)
         IDLE: begin
            if (req && any_hit) begin
               mem_resp      = 1'b1;
               lru_update    = 1'b1;
               lru_touch_way = hit_idx;
               hit_evt       = 1'b1;
               if (bus.mem_write) begin
                  load_data = WAYS'(1) << hit_idx;
                  set_dirty = WAYS'(1) << hit_idx;
               end
            end else if (req) begin
               victim_way_d = victim;
               miss_evt     = 1'b1;
               state_d      = (bus.way_valid[victim] && bus.way_dirty[victim]) ? WRITEBACK : FETCH;
            end
         end
         WRITEBACK: begin
            pmem_write    = 1'b1;
            pmem_addr_sel = 1'b1;
            if (bus.pmem_resp) begin
               wb_evt  = 1'b1;
               state_d = FETCH;
            end
         end
         FETCH: begin
            pmem_read = 1'b1;
            if (bus.pmem_resp) begin
               load_data = WAYS'(1) << victim_way_q;
               load_tag  = WAYS'(1) << victim_way_q;
               clr_dirty = WAYS'(1) << victim_way_q;
               data_sel  = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Reset abandons any pmem transaction and suppresses every strobe this cycle.
      if (rst) begin
         state_d       = IDLE;
         victim_way_d  = '0;
         mem_resp      = 1'b0;
         pmem_read     = 1'b0;
         pmem_write    = 1'b0;
         load_data     = '0;
         load_tag      = '0;
         set_dirty     = '0;
         clr_dirty     = '0;
         data_sel      = 1'b0;
         pmem_addr_sel = 1'b0;
         lru_update    = 1'b0;
         lru_touch_way = '0;
         hit_evt       = 1'b0;
         miss_evt      = 1'b0;
         wb_evt        = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         victim_way_q <= '0;
      end else begin
         state_q      <= state_d;
         victim_way_q <= victim_way_d;
      end
   end

   assign bus.mem_resp      = mem_resp;
   assign bus.pmem_read     = pmem_read;
   assign bus.pmem_write    = pmem_write;
   assign bus.load_data     = load_data;
   assign bus.load_tag      = load_tag;
   assign bus.set_dirty     = set_dirty;
   assign bus.clr_dirty     = clr_dirty;
   assign bus.data_sel      = data_sel;
   assign bus.pmem_addr_sel = pmem_addr_sel;
   assign bus.victim_way    = victim_way_q;
   assign bus.lru_update    = lru_update;
   assign bus.lru_touch_way = lru_touch_way;

`ifdef CACHE_PERF_CNT_EN
   logic [CNT_W-1:0] hit_count_q, hit_count_d;
   logic [CNT_W-1:0] miss_count_q, miss_count_d;
   logic [CNT_W-1:0] wb_count_q, wb_count_d;

   always_comb begin
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      wb_count_d   = wb_count_q;
      if (hit_evt  && !(&hit_count_q))  hit_count_d  = hit_count_q  + CNT_W'(1);
      if (miss_evt && !(&miss_count_q)) miss_count_d = miss_count_q + CNT_W'(1);
      if (wb_evt   && !(&wb_count_q))   wb_count_d   = wb_count_q   + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_count_q  <= '0;
         miss_count_q <= '0;
         wb_count_q   <= '0;
      end else begin
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
         wb_count_q   <= wb_count_d;
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;
   assign wb_count   = wb_count_q;
`else
   logic unused_evt;
   assign unused_evt = hit_evt | miss_evt | wb_evt;
`endif
endmodule

// File: tb/tb_cache_control_nway_wb.sv
// Directed cycle-by-cycle vector table for cache_control_nway_wb (WAYS=4) plus hand-written corner sequences.
module tb_cache_control_nway_wb;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cache_control_nway_wb_if #(.WAYS(4)) bus ();

`ifdef CACHE_PERF_CNT_EN
   logic [1:0] hit_count, miss_count, wb_count;
   cache_control_nway_wb #(.WAYS(4), .CNT_W(2)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
   );
`else
   cache_control_nway_wb #(.WAYS(4)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

   typedef struct packed {
      logic       mem_resp;
      logic       pmem_read;
      logic       pmem_write;
      logic [3:0] ld;
      logic [3:0] lt;
      logic [3:0] sd;
      logic [3:0] cd;
      logic       ds;
      logic       as;
      logic [1:0] vw;
      logic       lu;
      logic [1:0] tw;
   } out_t;

   typedef struct packed {
      logic       rst;
      logic       rd;
      logic       wr;
      logic       presp;
      logic [3:0] hit;
      logic [3:0] valid;
      logic [3:0] dirty;
      logic [1:0] lru;
      out_t       exp;
   } vec_t;

   int checks = 0;
   int errors = 0;
   vec_t vecs[$];

   function automatic out_t o(logic resp, logic prd, logic pwr, logic [3:0] ld, logic [3:0] lt,
                              logic [3:0] sd, logic [3:0] cd, logic ds, logic as,
                              logic [1:0] vw, logic lu, logic [1:0] tw);
      out_t r;
      r.mem_resp = resp; r.pmem_read = prd; r.pmem_write = pwr;
      r.ld = ld; r.lt = lt; r.sd = sd; r.cd = cd;
      r.ds = ds; r.as = as; r.vw = vw; r.lu = lu; r.tw = tw;
      return r;
   endfunction

   function automatic vec_t v(logic r, logic rd, logic wr, logic pr, logic [3:0] hit,
                              logic [3:0] valid, logic [3:0] dirty, logic [1:0] lru, out_t e);
      vec_t x;
      x.rst = r; x.rd = rd; x.wr = wr; x.presp = pr;
      x.hit = hit; x.valid = valid; x.dirty = dirty; x.lru = lru; x.exp = e;
      return x;
   endfunction

   function automatic out_t idle0(logic [1:0] vw);
      return o(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, vw, 0, 2'd0);
   endfunction

   function automatic out_t sample();
      out_t a;
      a.mem_resp = bus.mem_resp; a.pmem_read = bus.pmem_read; a.pmem_write = bus.pmem_write;
      a.ld = bus.load_data; a.lt = bus.load_tag; a.sd = bus.set_dirty; a.cd = bus.clr_dirty;
      a.ds = bus.data_sel; a.as = bus.pmem_addr_sel; a.vw = bus.victim_way;
      a.lu = bus.lru_update; a.tw = bus.lru_touch_way;
      return a;
   endfunction

   task automatic drive(logic r, logic rd, logic wr, logic pr, logic [3:0] hit,
                        logic [3:0] valid, logic [3:0] dirty, logic [1:0] lru);
      rst = r; bus.mem_read = rd; bus.mem_write = wr; bus.pmem_resp = pr;
      bus.way_hit = hit; bus.way_valid = valid; bus.way_dirty = dirty; bus.lru_way = lru;
   endtask

   task automatic check_out(string name, out_t exp);
      out_t act;
      act = sample();
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %07h want %07h (resp,prd,pwr,ld,lt,sd,cd,ds,as,vw,lu,tw)",
                  name, act, exp);
      end
   endtask

   task automatic check_val(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   initial begin
      // Cold fill of way 0, then hits.
      vecs.push_back(v(1,1,0,0,4'b0001,4'b0001,4'h0,2'd0, idle0(2'd0)));
      vecs.push_back(v(0,1,0,0,4'b0000,4'b0000,4'h0,2'd1, idle0(2'd0)));
      for (int i = 0; i < 5; i++)
         vecs.push_back(v(0,1,0,0,4'b0000,4'b0000,4'h0,2'd1, o(0,1,0,4'h0,4'h0,4'h0,4'h0,0,0,2'd0,0,2'd0)));
      vecs.push_back(v(0,1,0,1,4'b0000,4'b0000,4'h0,2'd1, o(0,1,0,4'h1,4'h1,4'h0,4'h1,1,0,2'd0,0,2'd0)));
      vecs.push_back(v(0,1,0,0,4'b0001,4'b0001,4'h0,2'd1, o(1,0,0,4'h0,4'h0,4'h0,4'h0,0,0,2'd0,1,2'd0)));
      vecs.push_back(v(0,0,1,0,4'b0100,4'b1111,4'h0,2'd0, o(1,0,0,4'h4,4'h0,4'h4,4'h0,0,0,2'd0,1,2'd2)));
      vecs.push_back(v(0,1,1,0,4'b1000,4'b1111,4'h0,2'd0, o(1,0,0,4'h8,4'h0,4'h8,4'h0,0,0,2'd0,1,2'd3)));
      vecs.push_back(v(0,1,0,0,4'b0110,4'b1111,4'h0,2'd0, o(1,0,0,4'h0,4'h0,4'h0,4'h0,0,0,2'd0,1,2'd1)));
      // Dirty LRU victim: writeback, fetch, hit.
      vecs.push_back(v(0,1,0,0,4'b0000,4'b1111,4'b1000,2'd3, idle0(2'd0)));
      vecs.push_back(v(0,1,0,0,4'b0000,4'b1111,4'b1000,2'd3, o(0,0,1,4'h0,4'h0,4'h0,4'h0,0,1,2'd3,0,2'd0)));
      vecs.push_back(v(0,1,0,0,4'b0000,4'b1111,4'b1000,2'd3, o(0,0,1,4'h0,4'h0,4'h0,4'h0,0,1,2'd3,0,2'd0)));
      vecs.push_back(v(0,1,0,1,4'b0000,4'b1111,4'b1000,2'd3, o(0,0,1,4'h0,4'h0,4'h0,4'h0,0,1,2'd3,0,2'd0)));
      vecs.push_back(v(0,1,0,0,4'b0000,4'b1111,4'b1000,2'd3, o(0,1,0,4'h0,4'h0,4'h0,4'h0,0,0,2'd3,0,2'd0)));
      vecs.push_back(v(0,1,0,1,4'b0000,4'b1111,4'b1000,2'd3, o(0,1,0,4'h8,4'h8,4'h0,4'h8,1,0,2'd3,0,2'd0)));
      vecs.push_back(v(0,1,0,0,4'b1000,4'b1111,4'b0000,2'd3, o(1,0,0,4'h0,4'h0,4'h0,4'h0,0,0,2'd3,1,2'd3)));
      // Invalid way beats lru_way; request dropped mid-miss still fills.
      vecs.push_back(v(0,1,0,0,4'b0000,4'b1011,4'b1111,2'd0, idle0(2'd3)));
      vecs.push_back(v(0,1,0,0,4'b0000,4'b1011,4'b1111,2'd0, o(0,1,0,4'h0,4'h0,4'h0,4'h0,0,0,2'd2,0,2'd0)));
      vecs.push_back(v(0,0,0,1,4'b0000,4'b1011,4'b1111,2'd0, o(0,1,0,4'h4,4'h4,4'h0,4'h4,1,0,2'd2,0,2'd0)));
      vecs.push_back(v(0,0,0,1,4'b0000,4'b1111,4'b1111,2'd0, idle0(2'd2)));
      // Clean valid victim goes straight to fetch; reset mid-fetch abandons it.
      vecs.push_back(v(0,1,0,0,4'b0000,4'b1111,4'b0111,2'd3, idle0(2'd2)));
      vecs.push_back(v(0,1,0,0,4'b0000,4'b1111,4'b0111,2'd3, o(0,1,0,4'h0,4'h0,4'h0,4'h0,0,0,2'd3,0,2'd0)));
      vecs.push_back(v(1,1,0,1,4'b0000,4'b1111,4'b0111,2'd3, idle0(2'd3)));
      vecs.push_back(v(0,0,0,1,4'b0000,4'b1111,4'b0111,2'd3, idle0(2'd0)));
      // Write miss into invalid way 0, then write hit.
      vecs.push_back(v(0,0,1,0,4'b0000,4'b1110,4'b1111,2'd2, idle0(2'd0)));
      vecs.push_back(v(0,0,1,1,4'b0000,4'b1110,4'b1111,2'd2, o(0,1,0,4'h1,4'h1,4'h0,4'h1,1,0,2'd0,0,2'd0)));
      vecs.push_back(v(0,0,1,0,4'b0001,4'b1111,4'b1110,2'd2, o(1,0,0,4'h1,4'h0,4'h1,4'h0,0,0,2'd0,1,2'd0)));

      drive(1,0,0,0,4'h0,4'h0,4'h0,2'd0);
      repeat (2) @(posedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i].rst, vecs[i].rd, vecs[i].wr, vecs[i].presp,
               vecs[i].hit, vecs[i].valid, vecs[i].dirty, vecs[i].lru);
         #1;
         check_out($sformatf("vec%0d", i), vecs[i].exp);
      end

      // pmem_resp must not combinationally reach pmem_read/pmem_write.
      @(negedge clk);
      drive(0,1,0,0,4'h0,4'b1111,4'b0010,2'd1);
      @(negedge clk);
      drive(0,1,0,0,4'h0,4'b1111,4'b0010,2'd1);
      #1;
      check_val("wb_pwr_no_resp", {30'd0, bus.pmem_write, bus.pmem_read}, 32'h2);
      check_val("wb_victim", {30'd0, bus.victim_way}, 32'd1);
      bus.pmem_resp = 1'b1;
      #1;
      check_val("wb_pwr_with_resp", {30'd0, bus.pmem_write, bus.pmem_read}, 32'h2);
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      #1;
      check_val("fetch_prd_no_resp", {29'd0, bus.pmem_write, bus.pmem_read, bus.pmem_addr_sel}, 32'h2);
      bus.pmem_resp = 1'b1;
      #1;
      check_val("fetch_prd_with_resp", {30'd0, bus.pmem_write, bus.pmem_read}, 32'h1);
      check_val("fetch_load_tag", {28'd0, bus.load_tag}, 32'h2);

`ifdef CACHE_PERF_CNT_EN
      @(negedge clk);
      drive(1,0,0,0,4'h0,4'h0,4'h0,2'd0);
      @(negedge clk);
      #1;
      check_val("cnt_reset", {26'd0, hit_count, miss_count, wb_count}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         drive(0,1,0,0,4'b0001,4'b1111,4'h0,2'd0);
         @(negedge clk);
      end
      drive(0,1,0,0,4'b0000,4'b1111,4'b0001,2'd0);
      @(negedge clk);
      drive(0,1,0,1,4'b0000,4'b1111,4'b0001,2'd0);
      @(negedge clk);
      drive(0,1,0,1,4'b0000,4'b1111,4'b0001,2'd0);
      @(negedge clk);
      drive(0,0,0,0,4'b0000,4'b1111,4'b0000,2'd0);
      #1;
      check_val("hit_count_sat", {30'd0, hit_count}, 32'd3);
      check_val("miss_count", {30'd0, miss_count}, 32'd1);
      check_val("wb_count", {30'd0, wb_count}, 32'd1);
`endif

      @(negedge clk);
      drive(1,0,0,0,4'h0,4'h0,4'h0,2'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
